// File: rtl/z80_vram_port.sv
// z80_vram_port: Z80 I/O-port front end that queues VRAM writes for an SDRAM writer.
// Optional VRAM_AUTOINC_EN: post-increment vram_addr on every data-port write.
module z80_vram_port #(
    parameter logic [7:0] BASE_PORT = 8'h40,
    parameter int         FIFO_AW   = 2
) (
    input  logic        clk64,
    input  logic        RESET,
    input  logic        IORQ,
    input  logic        WR,
    input  logic [7:0]  A,
    input  logic [7:0]  D,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        overflow,
    output logic [15:0] vram_addr
);
    localparam int PW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef struct packed {
        logic       iorq;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
    } bus_t;

    bus_t            bus_0_q, bus_1_q, bus_2_q;
    logic            ev, ev_lo, ev_hi, ev_data, ev_ctrl;
    logic            push_d, push_q;
    logic [23:0]     pdat_d, pdat_q;
    logic [15:0]     vaddr_d, vaddr_q;
    logic            ovf_d, ovf_q;
    logic [PW-1:0]   wptr_d, wptr_q, rptr_d, rptr_q;
    logic [23:0]     mem_q [DEPTH];
    logic            empty, full, pop, push_ok;

    always_comb begin
        // Event on the /WR rising edge while /IORQ is still low, seen at the end of the chain
        ev      = !bus_2_q.iorq && !bus_2_q.wr && bus_1_q.wr;
        ev_lo   = ev && (bus_2_q.a == BASE_PORT);
        ev_hi   = ev && (bus_2_q.a == BASE_PORT + 8'd1);
        ev_data = ev && (bus_2_q.a == BASE_PORT + 8'd2);
        ev_ctrl = ev && (bus_2_q.a == BASE_PORT + 8'd3);
        empty   = wptr_q == rptr_q;
        full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                  (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
        pop     = !empty && wr_ready;
        push_ok = push_q && (!full || pop);
        push_d  = ev_data;
        pdat_d  = {vaddr_q, bus_2_q.d};
        vaddr_d = ev_lo ? {vaddr_q[15:8], bus_2_q.d} :
                  ev_hi ? {bus_2_q.d, vaddr_q[7:0]} : vaddr_q;
`ifdef VRAM_AUTOINC_EN
        vaddr_d = ev_data ? vaddr_q + 16'd1 : vaddr_d;
`else
        vaddr_d = vaddr_d;
`endif
        ovf_d   = (ovf_q && !(ev_ctrl && bus_2_q.d[0])) || (push_q && !push_ok);
        wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PW'(1) : rptr_q;
    end

    always_ff @(posedge clk64 or negedge RESET) begin
        if (!RESET) begin
            bus_0_q <= '1;
            bus_1_q <= '1;
            bus_2_q <= '1;
            push_q  <= 1'b0;
            pdat_q  <= '0;
            vaddr_q <= '0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            bus_0_q <= '{iorq: IORQ, wr: WR, a: A, d: D};
            bus_1_q <= bus_0_q;
            bus_2_q <= bus_1_q;
            push_q  <= push_d;
            pdat_q  <= pdat_d;
            vaddr_q <= vaddr_d;
            ovf_q   <= ovf_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk64) begin
        if (push_ok) mem_q[wptr_q[FIFO_AW-1:0]] <= pdat_q;
    end

    assign wr_valid           = !empty;
    assign {wr_addr, wr_data} = mem_q[rptr_q[FIFO_AW-1:0]];
    assign overflow           = ovf_q;
    assign vram_addr          = vaddr_q;
endmodule

// File: tb/tb_z80_vram_port.sv
// tb_z80_vram_port: scoreboard bench for z80_vram_port; honours VRAM_AUTOINC_EN.
module tb_z80_vram_port;
    logic        clk64 = 1'b0, RESET = 1'b0, IORQ = 1'b1, WR = 1'b1, wr_ready = 1'b0;
    logic [7:0]  A = 8'h00, D = 8'h00;
    logic        wr_valid, overflow;
    logic [15:0] wr_addr, vram_addr;
    logic [7:0]  wr_data;
    int          n_chk = 0, n_pass = 0;
    logic [23:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [23:0] held = '0;

`ifdef VRAM_AUTOINC_EN
    localparam logic [15:0] INC = 16'd1;
`else
    localparam logic [15:0] INC = 16'd0;
`endif

    always #5 clk64 = ~clk64;

    z80_vram_port dut (
        .clk64(clk64), .RESET(RESET), .IORQ(IORQ), .WR(WR), .A(A), .D(D),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .overflow(overflow), .vram_addr(vram_addr)
    );

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk64);
        #1;
    endtask

    // One Z80 OUT cycle; rdy_on_push raises wr_ready only for the cycle the push lands
    task automatic io_wr(input logic [7:0] port, input logic [7:0] data,
                         input logic iorq_on, input logic rdy_on_push);
        A = port; D = data; IORQ = !iorq_on;
        tick(2);
        WR = 1'b0;
        tick(4);
        WR = 1'b1;
        if (rdy_on_push) begin
            tick(3); wr_ready = 1'b1;
            tick(1); wr_ready = 1'b0;
            tick(4);
        end else tick(8);
        IORQ = 1'b1;
        tick(3);
    endtask

    task automatic set_addr(input logic [15:0] ad);
        io_wr(8'h41, ad[15:8], 1'b1, 1'b0);
        io_wr(8'h40, ad[7:0], 1'b1, 1'b0);
    endtask

    task automatic drain(input string name);
        wr_ready = 1'b1;
        for (int i = 0; i < 50 && wr_valid; i++) tick(1);
        tick(1);
        check({name, "_empty"}, {23'd0, wr_valid}, 24'd0);
        check({name, "_left"}, 24'(exp_q.size()), 24'd0);
    endtask

    always @(negedge clk64) begin
        if (RESET && wr_valid && wr_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_beat: got %h expected none", {wr_addr, wr_data});
            end else check("beat", {wr_addr, wr_data}, exp_q.pop_front());
            stalled = 1'b0;
        end else if (RESET && wr_valid) begin
            if (stalled) check("hold", {wr_addr, wr_data}, held);
            stalled = 1'b1;
            held = {wr_addr, wr_data};
        end else stalled = 1'b0;
    end

    initial begin
        tick(3);
        check("rst_valid", {23'd0, wr_valid}, 24'd0);
        check("rst_vaddr", {8'd0, vram_addr}, 24'd0);
        check("rst_ovf", {23'd0, overflow}, 24'd0);
        RESET = 1'b1;
        tick(2);

        wr_ready = 1'b1;
        set_addr(16'h1234);
        check("addr_load", {8'd0, vram_addr}, 24'h001234);
        exp_q.push_back({16'h1234, 8'hAB});
        io_wr(8'h42, 8'hAB, 1'b1, 1'b0);
        drain("basic");
        check("addr_after_data", {8'd0, vram_addr}, {8'd0, 16'h1234 + INC});

        wr_ready = 1'b0;
        set_addr(16'h2000);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({16'(16'h2000 + INC * i), 8'(i + 1)});
            io_wr(8'h42, 8'(i + 1), 1'b1, 1'b0);
        end
        check("ovf_set", {23'd0, overflow}, 24'd1);
        check("full_valid", {23'd0, wr_valid}, 24'd1);
        check("addr_after_5", {8'd0, vram_addr}, {8'd0, 16'(16'h2000 + INC * 5)});
        io_wr(8'h43, 8'hFE, 1'b1, 1'b0);
        check("ovf_keep_d0_0", {23'd0, overflow}, 24'd1);
        io_wr(8'h43, 8'h01, 1'b1, 1'b0);
        check("ovf_clear", {23'd0, overflow}, 24'd0);
        drain("overflow");

        wr_ready = 1'b0;
        set_addr(16'h3000);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({16'(16'h3000 + INC * i), 8'(8'hA0 + i)});
            io_wr(8'h42, 8'(8'hA0 + i), 1'b1, 1'b0);
        end
        exp_q.push_back({16'(16'h3000 + INC * 4), 8'hA4});
        io_wr(8'h42, 8'hA4, 1'b1, 1'b1);
        check("full_pop_ovf", {23'd0, overflow}, 24'd0);
        check("full_pop_valid", {23'd0, wr_valid}, 24'd1);
        drain("full_pop");

        set_addr(16'h5678);
        io_wr(8'h50, 8'h77, 1'b1, 1'b0);
        io_wr(8'h42, 8'h55, 1'b0, 1'b0);
        tick(2);
        check("ignore_vaddr", {8'd0, vram_addr}, 24'h005678);
        check("ignore_valid", {23'd0, wr_valid}, 24'd0);
        check("ignore_ovf", {23'd0, overflow}, 24'd0);

`ifdef VRAM_AUTOINC_EN
        set_addr(16'hFFFF);
        exp_q.push_back({16'hFFFF, 8'h99});
        io_wr(8'h42, 8'h99, 1'b1, 1'b0);
        drain("wrap");
        check("wrap_vaddr", {8'd0, vram_addr}, 24'd0);
`endif

        wr_ready = 1'b0;
        set_addr(16'h0100);
        exp_q.push_back({16'h0100, 8'h11});
        io_wr(8'h42, 8'h11, 1'b1, 1'b0);
        exp_q.push_back({16'(16'h0100 + INC), 8'h22});
        io_wr(8'h42, 8'h22, 1'b1, 1'b0);
        check("pre_rst_valid", {23'd0, wr_valid}, 24'd1);
        RESET = 1'b0;
        #1;
        check("mid_rst_valid", {23'd0, wr_valid}, 24'd0);
        check("mid_rst_vaddr", {8'd0, vram_addr}, 24'd0);
        exp_q.delete();
        tick(2);
        RESET = 1'b1;
        tick(4);
        check("post_rst_valid", {23'd0, wr_valid}, 24'd0);
        wr_ready = 1'b1;
        exp_q.push_back({16'h0000, 8'hC3});
        io_wr(8'h42, 8'hC3, 1'b1, 1'b0);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/z80_vram_port.md
Z80_VRAM_PORT -- requirements
Module: z80_vram_port

Interface
REQ-001 SHALL have parameter BASE_PORT, default 'h40, meaning the Z80 I/O address of the address-low port (address-high = BASE_PORT+1, data = BASE_PORT+2, control = BASE_PORT+3).
REQ-002 SHALL have parameter FIFO_AW, default 2, meaning log2 of the write-request FIFO depth (depth 4).
REQ-003 SHALL have port clk64  input  1  meaning the SDRAM-domain clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port RESET  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port IORQ  input  1  meaning the raw Z80 /IORQ, active-low and asynchronous to clk64.
REQ-006 SHALL have port WR  input  1  meaning the raw Z80 /WR, active-low and asynchronous.
REQ-007 SHALL have port A  input  8  meaning the raw Z80 address bus, low byte.
REQ-008 SHALL have port D  input  8  meaning the raw Z80 data bus.
REQ-009 SHALL have port wr_valid  output  1  meaning the FIFO head holds a pending VRAM write.
REQ-010 SHALL have port wr_ready  input  1  meaning the downstream SDRAM writer accepts the head this cycle.
REQ-011 SHALL have port wr_addr  output  16  meaning the VRAM address of the head entry.
REQ-012 SHALL have port wr_data  output  8  meaning the VRAM data of the head entry.
REQ-013 SHALL have port overflow  output  1  meaning a sticky flag set when a write was dropped.
REQ-014 SHALL have port vram_addr  output  16  meaning the current address pointer.

Function
REQ-015 SHALL pass IORQ, WR, A and D each through a 3-flop synchronizer chain (stages _0, _1, _2).
REQ-016 SHALL detect an I/O write event in a cycle where iorq_2==0, wr_2==0 and wr_1==1; A and D SHALL be taken from stage _2.
REQ-017 SHALL generate at most one event per /WR rising edge.
REQ-018 SHALL, on an event at BASE_PORT, load vram_addr[7:0] from D; on an event at BASE_PORT+1, load vram_addr[15:8] from D.
REQ-019 SHALL, on an event at BASE_PORT+2, push {vram_addr, D} into the FIFO in the next cycle.
REQ-020 SHALL, on an event at BASE_PORT+3 with D[0]==1, clear overflow; other D bits SHALL be ignored.
REQ-021 SHALL ignore events at any other port address.
REQ-022 SHALL assert wr_valid whenever the FIFO is not empty; wr_addr and wr_data SHALL show the head combinationally from storage.
REQ-023 SHALL pop the head in a cycle where wr_valid && wr_ready; wr_ready with an empty FIFO SHALL have no effect.
REQ-024 SHALL accept a push when full only if a pop occurs in the same cycle; otherwise the push SHALL be dropped and overflow set to 1.
REQ-025 SHALL keep the pointer arithmetic modulo 2^FIFO_AW with a separate full/empty discriminator bit.
REQ-026 SHALL hold wr_addr and wr_data stable while wr_valid is high and wr_ready is low.

Reset
REQ-027 SHALL, while RESET==0, force vram_addr=0, overflow=0, wr_valid=0, FIFO empty and all synchronizer flops=1 (bus idle).
REQ-028 SHALL discard pending FIFO entries on a reset that occurs mid-operation; no event SHALL be detected in the first 3 cycles after release.

Configuration
REQ-029 SHALL, with VRAM_AUTOINC_EN defined, increment vram_addr by 1 (wrapping 'hFFFF->'h0000) in the same cycle as each data-port event, whether the push is accepted or dropped.
REQ-030 SHALL, without VRAM_AUTOINC_EN, change vram_addr only on address-port writes.

Verification
REQ-031 SHALL cover: OUT ('h41)='h12, OUT ('h40)='h34, OUT ('h42)='hAB -> one beat with wr_addr='h1234 and wr_data='hAB; vram_addr='h1235 if VRAM_AUTOINC_EN is defined, else 'h1234.
REQ-032 SHALL cover: wr_ready held 0, five OUT ('h42) writes -> 4 entries in order, the 5th dropped, overflow=1; OUT ('h43)='h01 -> overflow=0.
REQ-033 SHALL cover: a full FIFO with wr_ready=1 in the push cycle -> push accepted and overflow remains 0.
REQ-034 SHALL cover: vram_addr='hFFFF with VRAM_AUTOINC_EN, data write -> entry addr='hFFFF, vram_addr='h0000.
REQ-035 SHALL cover: OUT ('h50) and a /WR pulse with IORQ high -> no FIFO push and vram_addr unchanged.
REQ-036 SHALL cover: RESET low with 2 entries pending -> wr_valid=0 asynchronously, vram_addr=0.
